// File: rtl/spi_pkg.sv
// Shared constants for the SPI SFR sequencer: SFR address map, FSM state
// encoding and the helper that selects the transfer-done status bit.
package spi_pkg;

    // SFR write addresses
    localparam logic [2:0] ADDR_SPICR1 = 3'd0;
    localparam logic [2:0] ADDR_SPICR2 = 3'd1;
    localparam logic [2:0] ADDR_SPIBR  = 3'd2;
    localparam logic [2:0] ADDR_SPIDR1 = 3'd3;

    // SFR read addresses
    localparam logic [2:0] ADDR_SPISR  = 3'd3;
    localparam logic [2:0] ADDR_SPIDR2 = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG1  = 3'd1,
        CFG2  = 3'd2,
        CFG3  = 3'd3,
        WRDAT = 3'd4,
        WCLR  = 3'd5,
        WDONE = 3'd6,
        RDDAT = 3'd7
    } state_t;

    // Master transfers finish on SPISR[0], slave transfers on SPISR[1].
    function automatic logic done_bit(input logic mst, input logic [1:0] sr);
        return mst ? sr[0] : sr[1];
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word fall-through receive FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate count.
module spi_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [7:0]    mem [DEPTH];

    logic empty;
    logic pop;
    logic wr_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign pop   = !empty && rx_ready;
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign wr_en = push && (!full || pop);
    assign ovf   = push && full && !pop;

    assign rx_valid = !empty;
    assign rx_data  = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; reset discards any stored bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/spi_sfr_sequencer.sv
// Drives an SPI core through its SFR port: writes the three configuration
// registers on request, and for each byte to send writes SPIDR1, waits for
// the done bit to clear and then set, and reads SPIDR2 into the RX FIFO.
module spi_sfr_sequencer
    import spi_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd4096,
    parameter int          RXDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cfg_cr1,
    input  logic [7:0] cfg_cr2,
    input  logic [7:0] cfg_br,
    input  logic       cfg_go,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       sfrwe,
    output logic [2:0] sfraddr_w,
    output logic [7:0] spidata_o,
    output logic [2:0] sfraddr_r,
    input  logic [7:0] sfrdata_i,
    output logic       busy,
    output logic       timeout_err,
    output logic       rx_ovf
);

    state_t      state_reg;
    state_t      state_next;
    logic        mst_reg;
    logic [7:0]  tx_data_reg;
    logic [15:0] wait_cnt_reg;
    logic        timeout_err_reg;
    logic        rx_ovf_reg;
    logic        ready_en_reg;

    logic        done;
    logic        wait_hit;
    logic        in_wait;
    logic        tx_fire;
    logic        push;
    logic        fifo_full;
    logic        fifo_ovf;

    assign done     = done_bit(mst_reg, sfrdata_i[1:0]);
    assign wait_hit = (wait_cnt_reg == (TIMEOUT - 16'd1));
    assign in_wait  = (state_reg == WCLR) || (state_reg == WDONE);
    assign tx_fire  = tx_valid && tx_ready;

    assign timeout_err = timeout_err_reg;
    assign rx_ovf      = rx_ovf_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the timeout check wins over the done check.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_go) begin
                    state_next = CFG1;
                end else if (tx_fire) begin
                    state_next = WRDAT;
                end
            end
            CFG1:  state_next = CFG2;
            CFG2:  state_next = CFG3;
            CFG3:  state_next = IDLE;
            WRDAT: state_next = WCLR;
            WCLR: begin
                if (wait_hit) begin
                    state_next = IDLE;
                end else if (!done) begin
                    state_next = WDONE;
                end
            end
            WDONE: begin
                if (wait_hit) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = RDDAT;
                end
            end
            RDDAT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; the status register is the default read address.
    always_comb begin
        sfrwe     = 1'b0;
        sfraddr_w = 3'd0;
        spidata_o = 8'h00;
        sfraddr_r = ADDR_SPISR;
        tx_ready  = 1'b0;
        push      = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            IDLE: begin
                busy     = 1'b0;
                tx_ready = ready_en_reg && !cfg_go && !fifo_full;
            end
            CFG1: begin
                sfrwe     = 1'b1;
                sfraddr_w = ADDR_SPICR1;
                spidata_o = cfg_cr1;
            end
            CFG2: begin
                sfrwe     = 1'b1;
                sfraddr_w = ADDR_SPICR2;
                spidata_o = cfg_cr2;
            end
            CFG3: begin
                sfrwe     = 1'b1;
                sfraddr_w = ADDR_SPIBR;
                spidata_o = cfg_br;
            end
            WRDAT: begin
                sfrwe     = 1'b1;
                sfraddr_w = ADDR_SPIDR1;
                spidata_o = tx_data_reg;
            end
            RDDAT: begin
                sfraddr_r = ADDR_SPIDR2;
                push      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers: master/slave mode, byte to send, wait counter.
    // ready_en_reg keeps tx_ready low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_reg      <= 1'b1;
            tx_data_reg  <= 8'h00;
            wait_cnt_reg <= 16'd0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (state_reg == CFG1) begin
                mst_reg <= cfg_cr1[4];
            end
            if (tx_fire) begin
                tx_data_reg <= tx_data;
            end
            if (state_reg == WRDAT) begin
                wait_cnt_reg <= 16'd0;
            end else if (in_wait) begin
                wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
        end
    end

    // Sticky error flags, cleared by a configuration request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_reg <= 1'b0;
            rx_ovf_reg      <= 1'b0;
        end else begin
            if (in_wait && wait_hit) begin
                timeout_err_reg <= 1'b1;
            end else if (cfg_go) begin
                timeout_err_reg <= 1'b0;
            end
            if (fifo_ovf) begin
                rx_ovf_reg <= 1'b1;
            end else if (cfg_go) begin
                rx_ovf_reg <= 1'b0;
            end
        end
    end

    spi_rx_fifo #(
        .DEPTH(RXDEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(sfrdata_i),
        .full     (fifo_full),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .ovf      (fifo_ovf)
    );

endmodule

// File: tb/tb_spi_sfr_sequencer.sv
// Directed bench for spi_sfr_sequencer with a small SPI core model that
// completes a transfer 20 cycles after SPIDR1 is written and returns the
// written byte nibble-swapped in SPIDR2.
module tb_spi_sfr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg_cr1 = 8'h00;
    logic [7:0] cfg_cr2 = 8'h00;
    logic [7:0] cfg_br = 8'h00;
    logic       cfg_go = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       sfrwe;
    logic [2:0] sfraddr_w;
    logic [7:0] spidata_o;
    logic [2:0] sfraddr_r;
    logic [7:0] sfrdata_i;
    logic       busy;
    logic       timeout_err;
    logic       rx_ovf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_sfr_sequencer #(
        .TIMEOUT(16'd64),
        .RXDEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_cr1    (cfg_cr1),
        .cfg_cr2    (cfg_cr2),
        .cfg_br     (cfg_br),
        .cfg_go     (cfg_go),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .sfrwe      (sfrwe),
        .sfraddr_w  (sfraddr_w),
        .spidata_o  (spidata_o),
        .sfraddr_r  (sfraddr_r),
        .sfrdata_i  (sfrdata_i),
        .busy       (busy),
        .timeout_err(timeout_err),
        .rx_ovf     (rx_ovf)
    );

    // SPI core model
    logic [7:0] spisr_m;
    logic [7:0] spidr2_m;
    logic [7:0] wr_byte_m;
    int         mcnt;
    logic       mrun;
    logic       model_on = 1'b1;
    logic       model_slave = 1'b0;

    assign sfrdata_i = (sfraddr_r == 3'd3) ? spisr_m :
                       (sfraddr_r == 3'd5) ? spidr2_m : 8'h00;

    // Transfer model: clears status on a SPIDR1 write, sets the done bit 20 cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spisr_m   <= 8'h00;
            spidr2_m  <= 8'h00;
            wr_byte_m <= 8'h00;
            mcnt      <= 0;
            mrun      <= 1'b0;
        end else if (sfrwe && sfraddr_w == 3'd3) begin
            spisr_m   <= 8'h00;
            spidr2_m  <= 8'h00;
            wr_byte_m <= spidata_o;
            mcnt      <= 0;
            mrun      <= 1'b1;
        end else if (mrun) begin
            mcnt <= mcnt + 1;
            if (model_slave) spisr_m[0] <= ~spisr_m[0];
            if (model_on && mcnt == 19) begin
                mrun     <= 1'b0;
                spidr2_m <= {wr_byte_m[3:0], wr_byte_m[7:4]};
                spisr_m  <= model_slave ? 8'h02 : 8'h01;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Configuration request, issued together with tx_valid to exercise priority.
    task automatic do_cfg(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] br);
        @(negedge clk);
        cfg_cr1 = c1; cfg_cr2 = c2; cfg_br = br;
        cfg_go = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE;
        #1;
        chk("cfg_prio_tx_ready", {15'd0, tx_ready}, 16'd0);
        @(posedge clk); #1;
        cfg_go = 1'b0; tx_valid = 1'b0;
        @(negedge clk);
        chk("cfg1_we", {15'd0, sfrwe}, 16'd1);
        chk("cfg1_addr", {13'd0, sfraddr_w}, 16'd0);
        chk("cfg1_data", {8'd0, spidata_o}, {8'd0, c1});
        chk("cfg1_busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        chk("cfg2_addr", {12'd0, sfrwe, sfraddr_w}, 16'h9);
        chk("cfg2_data", {8'd0, spidata_o}, {8'd0, c2});
        @(negedge clk);
        chk("cfg3_addr", {12'd0, sfrwe, sfraddr_w}, 16'hA);
        chk("cfg3_data", {8'd0, spidata_o}, {8'd0, br});
        @(negedge clk);
        chk("cfg_end_we", {15'd0, sfrwe}, 16'd0);
        chk("cfg_end_busy", {15'd0, busy}, 16'd0);
        chk("cfg_clr_flags", {14'd0, timeout_err, rx_ovf}, 16'd0);
    endtask

    // Offer a byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d;
        #1;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("send_accept", {15'd0, tx_ready}, 16'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Count busy cycles until the sequencer is idle again (bounded).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy === 1'b1 && cycles < 500) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input logic [7:0] exp);
        @(negedge clk);
        chk("pop_valid", {15'd0, rx_valid}, 16'd1);
        chk("pop_data", {8'd0, rx_data}, {8'd0, exp});
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_sfrwe", {15'd0, sfrwe}, 16'd0);
        chk("rst_addr_r", {13'd0, sfraddr_r}, 16'd3);
        chk("rst_addr_w", {13'd0, sfraddr_w}, 16'd0);
        chk("rst_spidata", {8'd0, spidata_o}, 16'd0);
        chk("rst_tx_ready", {15'd0, tx_ready}, 16'd0);
        chk("rst_rx", {7'd0, rx_valid, rx_data}, 16'd0);
        chk("rst_flags", {14'd0, timeout_err, rx_ovf}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tx_ready", {15'd0, tx_ready}, 16'd1);

        // Master configuration
        do_cfg(8'h10, 8'h01, 8'h03);

        // Loopback byte
        send_byte(8'hA5);
        repeat (10) @(negedge clk);
        chk("lb_mid_busy", {14'd0, busy, rx_valid}, 16'h2);
        chk("lb_mid_addr_r", {13'd0, sfraddr_r}, 16'd3);
        wait_idle(n);
        n = n + 10;
        chk("lb_cycles", n[15:0], 16'd23);
        chk("lb_rx_valid", {15'd0, rx_valid}, 16'd1);
        chk("lb_rx_data", {8'd0, rx_data}, 16'h5A);
        pop_check(8'h5A);
        @(negedge clk);
        chk("lb_empty", {15'd0, rx_valid}, 16'd0);

        // Timeout: done never set
        model_on = 1'b0;
        send_byte(8'h3C);
        wait_idle(n);
        chk("to_cycles", n[15:0], 16'd65);
        chk("to_err", {15'd0, timeout_err}, 16'd1);
        chk("to_no_rx", {15'd0, rx_valid}, 16'd0);
        chk("to_no_ovf", {15'd0, rx_ovf}, 16'd0);
        model_on = 1'b1;

        // Reconfigure clears the sticky timeout
        do_cfg(8'h10, 8'h01, 8'h03);

        // FIFO full
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        wait_idle(n);
        chk("full_tx_ready", {15'd0, tx_ready}, 16'd0);
        chk("full_head", {8'd0, rx_data}, 16'h21);
        pop_check(8'h21);
        @(negedge clk);
        chk("after_pop_tx_ready", {15'd0, tx_ready}, 16'd1);
        pop_check(8'h43);
        pop_check(8'h65);
        pop_check(8'h87);
        @(negedge clk);
        chk("full_drained", {15'd0, rx_valid}, 16'd0);
        chk("full_no_ovf", {15'd0, rx_ovf}, 16'd0);

        // Slave mode: done on SPISR[1], SPISR[0] toggles meanwhile
        model_slave = 1'b1;
        do_cfg(8'h00, 8'h01, 8'h03);
        send_byte(8'hC3);
        wait_idle(n);
        chk("slv_cycles", n[15:0], 16'd23);
        chk("slv_rx_valid", {15'd0, rx_valid}, 16'd1);
        chk("slv_rx_data", {8'd0, rx_data}, 16'h3C);

        // Reset abort in WDONE (slave byte left in the FIFO)
        model_slave = 1'b0;
        model_on = 1'b0;
        send_byte(8'h99);
        repeat (5) @(negedge clk);
        chk("abort_pre_busy", {15'd0, busy}, 16'd1);
        chk("abort_pre_fifo", {15'd0, rx_valid}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_async", {13'd0, busy, sfrwe, rx_valid}, 16'd0);
        @(negedge clk);
        chk("abort_idle", {13'd0, busy, sfrwe, rx_valid}, 16'd0);
        chk("abort_addr_r", {13'd0, sfraddr_r}, 16'd3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release", {13'd0, tx_ready, rx_valid, busy}, 16'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_sfr_sequencer.md
SPI_SFR_SEQUENCER -- requirements
Module: spi_sfr_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd4096, giving the maximum clk cycles to wait for transfer done.
REQ-002 SHALL have parameter RXDEPTH, default 4, giving the number of receive FIFO entries (power of two).
REQ-003 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset: asynchronous, active-low).
REQ-004 SHALL have ports cfg_cr1, cfg_cr2 and cfg_br (input, 8 each), holding the values for SPICR1, SPICR2 and SPIBR.
REQ-005 SHALL have port cfg_go (input, 1), a single-cycle request to write the configuration.
REQ-006 SHALL have ports tx_valid (input, 1), tx_data (input, 8) and tx_ready (output, 1), forming the byte-to-send handshake.
REQ-007 SHALL have ports rx_valid (output, 1), rx_data (output, 8) and rx_ready (input, 1), forming the received-byte handshake.
REQ-008 SHALL have ports sfrwe (output, 1), sfraddr_w (output, 3) and spidata_o (output, 8), driving the SFR write port of the SPI core.
REQ-009 SHALL have ports sfraddr_r (output, 3) and sfrdata_i (input, 8), forming the SFR read port; read data is combinational in the same cycle.
REQ-010 SHALL have ports busy (output, 1), timeout_err (output, 1, sticky) and rx_ovf (output, 1, sticky).

Function
REQ-011 SHALL use this SFR map: write addresses 0=SPICR1, 1=SPICR2, 2=SPIBR, 3=SPIDR1; read addresses 3=SPISR (bit0 master done, bit1 slave done), 5=SPIDR2.
REQ-012 SHALL implement these FSM states: IDLE, CFG1, CFG2, CFG3, WRDAT, WCLR, WDONE, RDDAT.
REQ-013 SHALL, in IDLE with cfg_go=1, step IDLE->CFG1->CFG2->CFG3->IDLE, asserting sfrwe for one cycle per state at addresses 0, 1 and 2.
REQ-014 SHALL latch cfg_cr1[4] into the internal bit mst at CFG1; the done bit is SPISR[0] when mst=1, else SPISR[1].
REQ-015 SHALL give cfg_go priority over tx_valid when both are 1 in IDLE; tx_ready stays 0 in that cycle.
REQ-016 SHALL set tx_ready=1 only in IDLE when cfg_go=0 and the RX FIFO is not full; a transfer (tx_valid and tx_ready) moves the FSM to WRDAT.
REQ-017 SHALL, in WRDAT, drive sfrwe=1, sfraddr_w=3 and spidata_o=the latched tx_data for one cycle, then go to WCLR.
REQ-018 SHALL, in WCLR, hold sfraddr_r=3 and go to WDONE when the done bit is 0.
REQ-019 SHALL, in WDONE, hold sfraddr_r=3 and go to RDDAT when the done bit is 1.
REQ-020 SHALL, in RDDAT, drive sfraddr_r=5, push sfrdata_i into the RX FIFO in the same cycle, and return to IDLE.
REQ-021 SHALL keep a 16-bit wait counter that clears on entry to WCLR and increments in WCLR and WDONE.
REQ-022 SHALL, when the wait counter reaches TIMEOUT-1, set timeout_err, push nothing, and return to IDLE.
REQ-023 SHALL, on a push while the RX FIFO is full, drop the byte and set rx_ovf (reachable only on timeout-race paths).
REQ-024 SHALL clear both sticky flags (timeout_err, rx_ovf) on cfg_go.
REQ-025 SHALL drive sfrwe=0 and sfraddr_r=3 in every state not named in REQ-013, REQ-017 and REQ-020.
REQ-026 SHALL implement the RX FIFO as first-word fall-through: rx_valid = not empty; a pop occurs on rx_valid and rx_ready.
REQ-027 SHALL handle a simultaneous push and pop when full as a legal pass-through with no overflow.
REQ-028 SHALL use FIFO pointers of log2(RXDEPTH)+1 bits that wrap naturally.
REQ-029 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-030 SHALL, during reset, force state=IDLE, FIFO empty, counter=0, mst=1, and all outputs to 0 except sfraddr_r=3.
REQ-031 SHALL, on a reset assertion mid-transfer, abort immediately with no pending write or read, and the FIFO contents are lost.

Structure
REQ-032 SHALL place the SFR address constants and the FSM state encoding in the shared package spi_pkg.
REQ-033 SHALL implement the RX FIFO as the sub-module spi_rx_fifo.

Verification
REQ-034 SHALL cover configuration: cfg_go with 8'h10, 8'h01, 8'h03 -> three sfrwe pulses at addresses 0, 1, 2 with those data, mst=1.
REQ-035 SHALL cover a loopback byte: tx 8'hA5, model sets SPISR[0]=1 after 20 cycles with SPIDR2=8'h5A -> rx_data=8'h5A, busy deasserts.
REQ-036 SHALL cover timeout: with TIMEOUT=64 and done never set -> timeout_err=1 after 64 cycles in wait, no rx_valid.
REQ-037 SHALL cover FIFO full: 4 bytes sent with rx_ready=0 -> tx_ready=0 after the 4th; one pop -> tx_ready=1.
REQ-038 SHALL cover slave mode: cfg_cr1=8'h00, done on SPISR[1] only -> transfer completes, while SPISR[0] toggling is ignored.
REQ-039 SHALL cover reset abort: rst_n low in WDONE -> next cycle IDLE, sfrwe=0, rx_valid=0.
